// File: rtl/mem_stage.sv
// Memory-access stage: latches execute results, runs at most one req/ack data-bus
// transaction and emits a registered write-back packet. Optional macro: MEM_STAGE_MISALIGN_TRAP_EN.
//
// state    | meaning
// S_IDLE   | waiting for req, stage free
// S_ACCESS | bus request outstanding, timeout down-counter running
// S_RESP   | done pulse cycle, write-back packet valid
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  input  logic        rd_mem,
  input  logic        wr_mem,
  input  logic [31:0] rd_mem_addr,
  input  logic [31:0] wr_mem_addr,
  input  logic [31:0] wr_mem_data,
  input  logic        wr_regfile,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter is loaded with N-1 so that dmem_req stays high for exactly N cycles.
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [4:0]  r_rd, w_rd_nxt;
  logic        r_wrf, w_wrf_nxt;
  logic        r_is_load, w_is_load_nxt;

  logic        r_dmem_req, w_dmem_req_nxt;
  logic        r_dmem_we, w_dmem_we_nxt;
  logic [31:0] r_dmem_addr, w_dmem_addr_nxt;
  logic [31:0] r_dmem_wdata, w_dmem_wdata_nxt;
  logic [3:0]  r_dmem_wstrb, w_dmem_wstrb_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_wb_en, w_wb_en_nxt;
  logic [4:0]  r_wb_rd, w_wb_rd_nxt;
  logic [31:0] r_wb_data, w_wb_data_nxt;
  logic        r_err, w_err_nxt;

  logic        w_has_op;
  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_addr;
  logic [1:0]  w_lane;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_has_op = rd_mem | wr_mem;
  assign w_addr   = rd_mem ? rd_mem_addr : wr_mem_addr;
  assign w_lane   = w_addr[1:0];

  always_comb begin
    w_illegal = rd_mem & wr_mem;
    if (rd_mem && !wr_mem) begin
      case (funct3)
        3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
        default:                w_illegal = 1'b0;
      endcase
    end else if (wr_mem && !rd_mem) begin
      w_illegal = (funct3 >= 3'b011);
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) && w_lane[0]) ||
                      ((funct3[1:0] == 2'b10) && (w_lane != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << w_lane;
        w_wdata = {4{wr_mem_data[7:0]}};
      end
      2'b01: begin
        w_strb  = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wr_mem_data[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = wr_mem_data;
      end
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_funct3_nxt     = r_funct3;
    w_lane_nxt       = r_lane;
    w_rd_nxt         = r_rd;
    w_wrf_nxt        = r_wrf;
    w_is_load_nxt    = r_is_load;
    w_dmem_req_nxt   = r_dmem_req;
    w_dmem_we_nxt    = r_dmem_we;
    w_dmem_addr_nxt  = r_dmem_addr;
    w_dmem_wdata_nxt = r_dmem_wdata;
    w_dmem_wstrb_nxt = r_dmem_wstrb;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_wb_en_nxt      = r_wb_en;
    w_wb_rd_nxt      = r_wb_rd;
    w_wb_data_nxt    = r_wb_data;
    w_err_nxt        = r_err;

    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_busy_nxt    = 1'b1;
          w_funct3_nxt  = funct3;
          w_lane_nxt    = w_lane;
          w_rd_nxt      = rd;
          w_wrf_nxt     = wr_regfile;
          w_is_load_nxt = rd_mem;
          if (!w_has_op) begin
            w_state_nxt   = S_RESP;
            w_done_nxt    = 1'b1;
            w_wb_en_nxt   = wr_regfile;
            w_wb_rd_nxt   = rd;
            w_wb_data_nxt = result;
            w_err_nxt     = 1'b0;
          end else if (w_illegal || w_misalign) begin
            w_state_nxt = S_RESP;
            w_done_nxt  = 1'b1;
            w_wb_en_nxt = 1'b0;
            w_wb_rd_nxt = rd;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt      = S_ACCESS;
            w_dmem_req_nxt   = 1'b1;
            w_dmem_we_nxt    = wr_mem;
            w_dmem_addr_nxt  = {w_addr[31:2], 2'b00};
            w_dmem_wstrb_nxt = rd_mem ? 4'b0000 : w_strb;
            w_dmem_wdata_nxt = w_wdata;
            w_cnt_nxt        = TO_LOAD;
          end
        end
      end

      S_ACCESS: begin
        // Ack is checked first so a response on the expiry cycle still completes.
        if (dmem_ack) begin
          w_state_nxt    = S_RESP;
          w_dmem_req_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_wb_en_nxt    = r_is_load & r_wrf;
          w_err_nxt      = 1'b0;
          if (r_is_load) begin
            w_wb_data_nxt = w_load_val;
          end
        end else if (r_cnt == 16'd0) begin
          w_state_nxt    = S_RESP;
          w_dmem_req_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_wb_en_nxt    = 1'b0;
          w_err_nxt      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      S_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
      r_rd         <= 5'd0;
      r_wrf        <= 1'b0;
      r_is_load    <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_funct3     <= w_funct3_nxt;
      r_lane       <= w_lane_nxt;
      r_rd         <= w_rd_nxt;
      r_wrf        <= w_wrf_nxt;
      r_is_load    <= w_is_load_nxt;
      r_dmem_req   <= w_dmem_req_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
      r_dmem_wstrb <= w_dmem_wstrb_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_wb_en      <= w_wb_en_nxt;
      r_wb_rd      <= w_wb_rd_nxt;
      r_wb_data    <= w_wb_data_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_wstrb = r_dmem_wstrb;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wb_en      = r_wb_en;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a behavioural model of the
// load/store rules; honours MEM_STAGE_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] result;
  logic        rd_mem, wr_mem;
  logic [31:0] rd_mem_addr, wr_mem_addr, wr_mem_data;
  logic        wr_regfile;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        busy, done, wb_en, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .funct3(funct3), .rd(rd), .result(result),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .rd_mem_addr(rd_mem_addr), .wr_mem_addr(wr_mem_addr),
    .wr_mem_data(wr_mem_data), .wr_regfile(wr_regfile),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem;
    logic        trap;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // What the bus should see when an op is accepted, from the architectural rules.
  function automatic exp_t model_issue(input logic [2:0] f3, input logic rm, input logic wm,
                                       input logic [31:0] ra, input logic [31:0] wa,
                                       input logic [31:0] wd);
    exp_t        e;
    int unsigned addr, a, size;
    bit          legal;
    e = '0;
    if (!rm && !wm) return e;
    addr = rm ? ra : wa;
    a    = addr % 4;
    size = (f3 % 4 == 1) ? 2 : ((f3 % 4 == 2) ? 4 : 1);
    if (rm && wm)  legal = 1'b0;
    else if (rm)   legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else           legal = (f3 <= 2);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    if (a % size != 0) legal = 1'b0;
`endif
    if (!legal) begin
      e.trap = 1'b1;
      return e;
    end
    e.mem  = 1'b1;
    e.we   = wm;
    e.addr = addr - a;
    if (wm) begin
      if (size == 1) begin
        e.strb  = 4'(1 << a);
        e.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (size == 2) begin
        e.strb  = 4'(3 << ((a / 2) * 2));
        e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        e.strb  = 4'hF;
        e.wdata = wd;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned a,
                                             input logic [31:0] rdat);
    logic [31:0] b, h;
    b = (rdat >> (8 * a)) & 32'hFF;
    h = (rdat >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdat;
    endcase
  endfunction

  // Junk on the upstream inputs while the stage is busy must not disturb it.
  task automatic scramble();
    req         = 1'b1;
    funct3      = 3'($urandom);
    rd          = 5'($urandom);
    result      = $urandom;
    rd_mem      = 1'($urandom);
    wr_mem      = 1'($urandom);
    rd_mem_addr = $urandom;
    wr_mem_addr = $urandom;
    wr_mem_data = $urandom;
    wr_regfile  = 1'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic rm, input logic wm,
                        input logic [4:0] rdx, input logic [31:0] res,
                        input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                        input logic wrf, input int ack_wait, input logic [31:0] rdat);
    exp_t        e;
    int          cyc;
    logic        exp_err, exp_en;
    logic [31:0] exp_data;
    bit          chk_data;
    int unsigned a;
    e = model_issue(f3, rm, wm, ra, wa, wd);
    a = (rm ? ra : wa) % 4;
    funct3 = f3; rd_mem = rm; wr_mem = wm; rd = rdx; result = res;
    rd_mem_addr = ra; wr_mem_addr = wa; wr_mem_data = wd; wr_regfile = wrf;
    req = 1'b1;
    @(posedge clk); #1;
    scramble();
    if (!e.mem) begin
      exp_err  = e.trap;
      exp_en   = e.trap ? 1'b0 : wrf;
      exp_data = res;
      chk_data = !e.trap;
      check_val("dmem_req_nomem", dmem_req, 0);
    end else begin
      check_val("dmem_req_rise", dmem_req, 1);
      check_val("dmem_we", dmem_we, e.we);
      check_val("dmem_wstrb", dmem_wstrb, e.strb);
      if (e.we) check_val("dmem_wdata", dmem_wdata, e.wdata);
      cyc = 0;
      while (dmem_req === 1'b1 && cyc < TO + 3) begin
        check_val("busy_access", busy, 1);
        check_val("dmem_addr", dmem_addr, e.addr);
        dmem_ack   = (cyc == ack_wait);
        dmem_rdata = (cyc == ack_wait) ? rdat : $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        cyc++;
      end
      exp_err  = (ack_wait >= TO);
      check_val("req_cycles", cyc, exp_err ? TO : ack_wait + 1);
      exp_en   = !exp_err && rm && wrf;
      exp_data = model_load(f3, a, rdat);
      chk_data = !exp_err && rm;
    end
    check_val("done_pulse", done, 1);
    check_val("err", err, exp_err);
    check_val("wb_en", wb_en, exp_en);
    check_val("wb_rd", wb_rd, rdx);
    if (chk_data) check_val("wb_data", wb_data, exp_data);
    dmem_ack   = 1'b1;
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    req      = 1'b0;
    check_val("done_low", done, 0);
    check_val("busy_free", busy, 0);
    check_val("dmem_req_late_ack", dmem_req, 0);
    check_val("err_hold", err, exp_err);
    check_val("wb_en_hold", wb_en, exp_en);
    check_val("wb_rd_hold", wb_rd, rdx);
  endtask

  task automatic reset_mid_access();
    funct3 = 3'b010; rd_mem = 1'b1; wr_mem = 1'b0; rd = 5'd9; rd_mem_addr = 32'h40;
    wr_regfile = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check_val("rst_req_c1", dmem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_dmem_req", dmem_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_wb_en", wb_en, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("rst_no_done", done, 0);
      check_val("rst_no_req", dmem_req, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned kind;
    logic        rm, wm;
    reset = 1'b1; req = 1'b0; funct3 = '0; rd = '0; result = '0; rd_mem = 1'b0; wr_mem = 1'b0;
    rd_mem_addr = '0; wr_mem_addr = '0; wr_mem_data = '0; wr_regfile = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_val_req", dmem_req, 0);
    check_val("rst_val_we", dmem_we, 0);
    check_val("rst_val_addr", dmem_addr, 0);
    check_val("rst_val_wdata", dmem_wdata, 0);
    check_val("rst_val_wstrb", dmem_wstrb, 0);
    check_val("rst_val_busy", busy, 0);
    check_val("rst_val_done", done, 0);
    check_val("rst_val_wb_en", wb_en, 0);
    check_val("rst_val_wb_rd", wb_rd, 0);
    check_val("rst_val_wb_data", wb_data, 0);
    check_val("rst_val_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'b000, 0, 0, 5'd5, 32'h1234, 0, 0, 0, 1, 0, 0);
    run_op(3'b000, 1, 0, 5'd7, 32'h0, 32'h103, 0, 0, 1, 3, 32'h80FF_0000);
    run_op(3'b001, 0, 1, 5'd3, 32'h0, 0, 32'h202, 32'hAABB_CCDD, 1, 0, 0);
    run_op(3'b010, 1, 0, 5'd4, 32'h0, 32'h400, 0, 0, 1, TO + 1, 32'h1111_1111);
    run_op(3'b010, 1, 0, 5'd6, 32'h0, 32'h400, 0, 0, 1, TO - 1, 32'hCAFE_F00D);
    run_op(3'b010, 1, 0, 5'd8, 32'h0, 32'h001, 0, 0, 1, 1, 32'h1357_9BDF);
    run_op(3'b010, 1, 1, 5'd2, 32'h0, 32'h10, 32'h20, 32'h5, 1, 0, 0);
    run_op(3'b011, 1, 0, 5'd2, 32'h0, 32'h10, 0, 0, 1, 0, 0);
    run_op(3'b011, 0, 1, 5'd2, 32'h0, 0, 32'h10, 32'h5, 1, 0, 0);
    run_op(3'b101, 1, 0, 5'd12, 32'h0, 32'h7002, 0, 0, 1, 2, 32'h8001_7FFF);
    reset_mid_access();
    run_op(3'b000, 0, 0, 5'd10, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom % 8;
      rm   = (kind >= 2 && kind <= 4) || kind == 7;
      wm   = (kind >= 5);
      run_op(3'($urandom), rm, wm, 5'($urandom), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the toy-scheme RV32I FPGA core, directly downstream of the execute stage. Captures the execute results (ALU result, load/store addresses, store data, control flags) on a request, performs at most one data-memory transaction over a req/ack bus, and presents a registered write-back packet with a one-cycle `done` pulse. Handles LB/LH/LW/LBU/LHU and SB/SH/SW lane steering, with a bus timeout.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles `dmem_req` stays high without `dmem_ack` before abort; range 1..65535.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  execute stage result valid; sampled only when `busy`=0
- `funct3`  in  3  load/store width and sign code
- `rd`  in  5  destination register, passed through
- `result`  in  32  execute ALU result / link value
- `rd_mem`, `wr_mem`  in  1 each  load / store request flags
- `rd_mem_addr`, `wr_mem_addr`  in  32 each  byte addresses
- `wr_mem_data`  in  32  store data (rs2)
- `wr_regfile`  in  1  instruction writes rd
- `dmem_req`  out  1  bus request, held until ack
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address (byte address with [1:0]=0)
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_wstrb`  out  4  byte enables
- `dmem_ack`  in  1  one-cycle transaction complete
- `dmem_rdata`  in  32  read word, valid with ack
- `busy`  out  1  stage occupied; upstream must hold
- `done`  out  1  one-cycle pulse, write-back packet valid
- `wb_en`  out  1  register-file write enable (qualified by `done`)
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  write-back value
- `err`  out  1  with `done`: timeout, illegal op, or misalign (see Configuration)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, `req`=1: latch all inputs; `busy`←1.
  - No memory op (`rd_mem`=`wr_mem`=0): go RESP; `wb_data`=`result`, `wb_en`=`wr_regfile`.
  - `rd_mem`=`wr_mem`=1 or unsupported funct3 (load: 011,110,111; store: ≥011): go RESP with `err`=1, `wb_en`=0, no bus access.
  - Otherwise: go ACCESS; `dmem_req`=1, address/strobe/data driven and held stable.
- Store lanes (a = addr[1:0]): SB `wstrb`=0001<<a, wdata={4{data[7:0]}}; SH `wstrb`=0011<<(2·a[1]), wdata={2{data[15:0]}}; SW `wstrb`=1111, wdata=data. Loads: `wstrb`=0000.
- Load extract: byte = rdata[8a+7:8a], half = rdata[16a[1]+15:16a[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- ACCESS: on `dmem_ack`: `dmem_req`←0, go RESP; load → `wb_data`=extracted, `wb_en`=`wr_regfile`; store → `wb_en`=0.
- ACCESS timeout: counter counts cycles with `dmem_req`=1; when it reaches `TIMEOUT_CYCLES` without ack, `dmem_req`←0, go RESP, `err`=1, `wb_en`=0. Ack arriving in the same cycle as expiry wins (normal completion).
- RESP: `done`=1 for exactly one cycle, `busy`←0, return to IDLE. A new `req` is accepted the cycle after RESP.
- `req` while `busy`=1 is ignored.
- `dmem_ack` outside ACCESS is ignored.

## Timing
- Reset values: `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_wstrb`=0, `busy`=0, `done`=0, `wb_en`=0, `wb_rd`=0, `wb_data`=0, `err`=0; state IDLE; timeout counter 0.
- All outputs registered.
- Non-memory op: `req` sampled at edge N → `done` high in cycle N+1 → next accept at edge N+2.
- Memory op: `dmem_req` high from cycle N+1; ack sampled at edge M → `done` high in cycle M+1. Zero-wait ack (ack in cycle N+1) → `done` in N+2.
- Reset mid-ACCESS: `dmem_req` low the cycle after the reset edge; no `done`; no write-back.
- `wb_*` and `err` hold their values after `done` until the next RESP.

## Configuration
- `MEM_STAGE_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠0 issue no bus access; RESP next cycle with `err`=1, `wb_en`=0.
- Undefined: misaligned low bits are dropped (half uses a[1], word ignores a[1:0]); the access proceeds normally with `err`=0.

## Test plan
- Non-memory: `req`, result=0x1234, `wr_regfile`=1, rd=5 → `done` next cycle, `wb_en`=1, `wb_rd`=5, `wb_data`=0x1234, `dmem_req` never high.
- LB at 0x103, ack after 3 wait cycles with rdata=0x80FF_0000 → `dmem_addr`=0x100, `wstrb`=0000, `wb_data`=0xFFFF_FF80, `done` the cycle after ack.
- SH at 0x202, data=0xAABB_CCDD, zero-wait ack → `dmem_we`=1, `wstrb`=1100, `wdata`=0xCCDD_CCDD, `wb_en`=0, `err`=0.
- Timeout with `TIMEOUT_CYCLES`=4: LW, no ack → `dmem_req` high exactly 4 cycles, then `done` with `err`=1, `wb_en`=0; a late ack is ignored.
- Misaligned LW at 0x001: with macro → no `dmem_req`, `err`=1; without → `dmem_addr`=0x000, normal completion.
- Reset asserted in cycle 2 of ACCESS → `dmem_req`=0 and `busy`=0 after that edge, no `done`; the following `req` is handled normally.
